fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
Each producer uses a valid/ready handshake. The arbiter drives the FIFO's wr_en and data_in and back-pressures on full.
A granted producer may hold the port for up to BURST_LEN consecutive words, so bursts are not interleaved.
The block sits directly in front of sync_fifo, and the FIFO is otherwise unchanged.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the sync_fifo write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE waits for a grant, BURST holds the port)
//   clog2_min1  : $clog2 clamped to at least 1, used for index widths
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned DefaultNumReq = 4;
  localparam int unsigned DefaultIdW    = clog2_min1(DefaultNumReq);

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of req, scanning from start upwards and
// wrapping modulo N.
//   req   : request vector
//   start : index with highest priority (must be < N)
//   found : at least one request is set
//   idx   : index of the chosen request (0 when none)
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IDW:0] sum;

  always_comb begin
    // Rotating the doubled vector puts req[start] at bit 0, so a plain priority encoder
    // on the rotated bits gives the scan order start, start+1, ... with wrap.
    rot   = N'({req, req} >> start);
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (IDW + 1)'(k);
        if (sum >= (IDW + 1)'(N)) begin
          sum = sum - (IDW + 1)'(N);
        end
        idx = sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ producers.
// A granted producer keeps the port for up to BURST_LEN consecutive words.
//   clk, rst     : clock, synchronous active-high reset (outputs forced to zero while high)
//   req_valid    : per-producer word valid
//   req_data     : packed producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : one-hot-or-zero; a word moves when valid[i] & ready[i]
//   fifo_full    : FIFO full flag, used combinationally so no write happens while full
//   fifo_wr_en   : FIFO write enable
//   fifo_data_in : FIFO write data (zero when no transfer)
//   grant_id     : current owner, or last owner when idle
//   busy         : high while a burst holds the port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned ID_W      = clog2_min1(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] ready_raw;
  logic [ID_W-1:0]    gid_raw;
  logic [NUM_REQ-1:0] xfer;

  // Explicit compare keeps the wrap correct for non-power-of-2 NUM_REQ.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ready_raw = '0;
    gid_raw   = owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          ready_raw[pick_idx] = 1'b1;
          owner_d             = pick_idx;
          gid_raw             = pick_idx;
          cnt_d               = CNT_W'(1);
          if (BURST_LEN == 1) begin
            rr_ptr_d = next_id(pick_idx);
          end else begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (!req_valid[owner_q]) begin
          // Owner went quiet: give the port up without a transfer this cycle.
          state_d  = IDLE;
          rr_ptr_d = next_id(owner_q);
          cnt_d    = '0;
        end else if (!fifo_full) begin
          ready_raw[owner_q] = 1'b1;
          if (cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
            state_d  = IDLE;
            rr_ptr_d = next_id(owner_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = rst ? '0 : ready_raw;
  assign xfer       = req_valid & req_ready;
  assign fifo_wr_en = |xfer;
  assign grant_id   = rst ? '0 : gid_raw;
  assign busy       = !rst && (state_q == BURST);

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (xfer[i]) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by randomized traffic, every cycle
// compared against a behavioural model of the grant rules.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned BL  = 4;
  localparam int unsigned IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .BURST_LEN  (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // Producers must hold valid and data steady until accepted.
  for (genvar g = 0; g < int'(N); g++) begin : g_prod
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[g] && !req_ready[g]) |=> (req_valid[g] && $stable(req_data[g*DW +: DW])));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: holder is the producer owning a burst (-1 when none), nxt is where the next
  // scan starts, last is the most recent grantee.
  int m_holder = -1;
  int m_words  = 0;
  int m_next   = 0;
  int m_last   = 0;

  logic [N-1:0]  e_ready;
  logic          e_wr;
  logic [DW-1:0] e_data;
  int            e_gid;
  logic          e_busy;
  int            e_pick;

  logic [N-1:0]   s_ready;
  logic           s_wr;
  logic [DW-1:0]  s_data;
  logic [IDW-1:0] s_gid;
  logic           s_busy;
  logic [N-1:0]   hs = '0;

  task automatic model_eval();
    e_ready = '0;
    e_pick  = -1;
    e_busy  = 1'b0;
    e_gid   = 0;
    if (!rst) begin
      e_busy = (m_holder >= 0);
      e_gid  = m_last;
      if (m_holder < 0) begin
        for (int k = 0; k < int'(N); k++) begin
          if (e_pick < 0 && req_valid[(m_next + k) % N]) e_pick = (m_next + k) % N;
        end
        if (e_pick >= 0 && !fifo_full) begin
          e_ready[e_pick] = 1'b1;
          e_gid           = e_pick;
        end
      end else begin
        e_gid = m_holder;
        if (req_valid[m_holder] && !fifo_full) e_ready[m_holder] = 1'b1;
      end
    end
    e_wr   = |(e_ready & req_valid);
    e_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (e_ready[i] && req_valid[i]) e_data = req_data[i*DW +: DW];
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_holder = -1;
      m_words  = 0;
      m_next   = 0;
      m_last   = 0;
    end else if (m_holder < 0) begin
      if (e_wr) begin
        m_last  = e_pick;
        m_words = 1;
        if (BL == 1) m_next = (e_pick + 1) % N;
        else m_holder = e_pick;
      end
    end else if (!req_valid[m_holder]) begin
      m_next   = (m_holder + 1) % N;
      m_holder = -1;
      m_words  = 0;
    end else if (e_wr) begin
      m_words++;
      if (m_words == int'(BL)) begin
        m_next   = (m_holder + 1) % N;
        m_holder = -1;
        m_words  = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge, then give
  // accepted producers fresh data.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    s_ready = req_ready;
    s_wr    = fifo_wr_en;
    s_data  = fifo_data_in;
    s_gid   = grant_id;
    s_busy  = busy;
    hs      = req_valid & req_ready;
    check_val("req_ready", 32'(s_ready), 32'(e_ready));
    check_val("fifo_wr_en", 32'(s_wr), 32'(e_wr));
    check_val("fifo_data_in", 32'(s_data), 32'(e_data));
    check_val("grant_id", 32'(s_gid), 32'(e_gid));
    check_val("busy", 32'(s_busy), 32'(e_busy));
    @(posedge clk);
    model_commit();
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (hs[i]) req_data[i*DW +: DW] = 8'($urandom);
    end
  endtask

  int wr_count;

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '1;
    req_data  = 32'($urandom);

    // Reset held with everyone requesting: nothing may move.
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("rst_wr_en", 32'(s_wr), 32'(0));
      check_val("rst_ready", 32'(s_ready), 32'(0));
      check_val("rst_busy", 32'(s_busy), 32'(0));
    end
    rst = 1'b0;

    // Full contention: four-word bursts rotating 0,1,2,3,0.
    for (int k = 0; k < 17; k++) begin
      cycle();
      check_val("rr_owner", 32'(s_gid), 32'((k / 4) % 4));
      check_val("rr_wr_en", 32'(s_wr), 32'(1));
    end

    // Single producer 2 streaming A0..A5.
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_val("single_data", 32'(s_data), 32'(8'hA0 + k));
      check_val("single_wr_en", 32'(s_wr), 32'(1));
      check_val("single_gid", 32'(s_gid), 32'(2));
      check_val("single_busy", 32'(s_busy), 32'(k != 0 && k != 4));
      req_data[2*DW +: DW] = 8'(8'hA1 + k);
    end
    req_valid = '0;
    cycle();

    // Back-pressure in the middle of producer 1's burst.
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = 4'b0010;
    wr_count  = 0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      wr_count += int'(s_wr);
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      wr_count += int'(s_wr);
      check_val("full_wr_en", 32'(s_wr), 32'(0));
      check_val("full_ready", 32'(s_ready), 32'(0));
      check_val("full_busy", 32'(s_busy), 32'(1));
      check_val("full_gid", 32'(s_gid), 32'(1));
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      wr_count += int'(s_wr);
      check_val("resume_wr_en", 32'(s_wr), 32'(1));
    end
    req_valid = '0;
    cycle();
    wr_count += int'(s_wr);
    check_val("full_total_words", 32'(wr_count), 32'(4));

    // Early release by producer 0 while 1 and 3 wait.
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = 4'b1011;
    cycle();
    check_val("early_first_gid", 32'(s_gid), 32'(0));
    req_valid[0] = 1'b0;
    cycle();
    check_val("early_gap_wr_en", 32'(s_wr), 32'(0));
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val("early_gid", 32'(s_gid), 32'((k < 4) ? 1 : 3));
      check_val("early_wr_en", 32'(s_wr), 32'(1));
    end

    // Reset in the middle of producer 3's burst.
    rst       = 1'b1;
    req_valid = '1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 14; k++) cycle();
    check_val("pre_abort_gid", 32'(s_gid), 32'(3));
    rst = 1'b1;
    cycle();
    check_val("abort_wr_en", 32'(s_wr), 32'(0));
    check_val("abort_ready", 32'(s_ready), 32'(0));
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val("post_abort_gid", 32'(s_gid), 32'((k < 4) ? 0 : 1));
      check_val("post_abort_busy", 32'(s_busy), 32'(k >= 1 && k <= 3));
    end

    // Randomized traffic with occasional full and reset.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i]         = ($urandom_range(0, 3) != 0);
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
